// File: rtl/button_pkg.sv
// Shared constants and helpers for the multi-channel button debouncer.
// Optional long-press detection is enabled with BUTTON_DEBOUNCE_HOLD_EN.
package button_pkg;

  // Depth of the metastability synchroniser in front of each channel.
  localparam int unsigned SYNC_STAGES = 2;

  // Width of a counter that must hold every value from 0 up to max_val.
  // Never returns less than 1 so a degenerate parameter still yields a legal vector.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage : button_pkg

// File: rtl/debounce_channel.sv
// One debounced button: synchroniser, integration counter, stable level,
// press/release pulses and (with BUTTON_DEBOUNCE_HOLD_EN) a long-press pulse.
module debounce_channel
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CNT = 16,
  parameter bit          ACTIVE_LOW   = 1'b0,
  parameter int unsigned HOLD_CNT     = 1024
) (
  input  logic clkIn,
  input  logic rstIn,
  input  logic buttonIn,
  output logic buttonOut,
  output logic pressOut,
  output logic releaseOut,
  output logic holdOut
);

  // A zero-length integration window would accept every glitch; refuse to build it.
  if (DEBOUNCE_CNT == 0) begin : g_bad_debounce_cnt
    $error("debounce_channel: DEBOUNCE_CNT must be >= 1");
  end

  // A zero hold window would fire on the press itself, which is meaningless.
  if (HOLD_CNT == 0) begin : g_bad_hold_cnt
    $error("debounce_channel: HOLD_CNT must be >= 1");
  end

  localparam int unsigned     CNT_W    = cnt_width(DEBOUNCE_CNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  logic                   btn_in;
  logic                   sync_lvl;
  logic [SYNC_STAGES-1:0] sync_q,    sync_d;
  logic                   stable_q,  stable_d;
  logic [CNT_W-1:0]       cnt_q,     cnt_d;
  logic                   press_q,   press_d;
  logic                   release_q, release_d;

  // Normalise polarity before synchronising so everything downstream means "pressed".
  assign btn_in   = buttonIn ^ ACTIVE_LOW;
  assign sync_lvl = sync_q[SYNC_STAGES-1];

  // Next-state: shift the synchroniser and integrate disagreement with the stable level.
  always_comb begin
    // NOTE: every _d gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    sync_d    = {sync_q[SYNC_STAGES-2:0], btn_in};
    stable_d  = stable_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;

    if (sync_lvl == stable_q) begin
      // Input agrees with the accepted level (or bounced back): forget any partial count.
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // New level held for the full window: accept it and flag the edge in the same cycle.
      stable_d  = sync_lvl;
      cnt_d     = '0;
      press_d   = sync_lvl;
      release_d = ~sync_lvl;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State register with synchronous reset; everything returns to "released".
  always_ff @(posedge clkIn) begin
    // NOTE: non-blocking assignments here so every register samples the pre-edge values of the others.
    if (rstIn) begin
      sync_q    <= '0;
      stable_q  <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign buttonOut  = stable_q;
  assign pressOut   = press_q;
  assign releaseOut = release_q;

`ifdef BUTTON_DEBOUNCE_HOLD_EN
  localparam int unsigned       HOLD_W    = cnt_width(HOLD_CNT);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CNT);

  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              hold_q,     hold_d;

  // Hold timer: counts cycles of accepted press, saturates, and pulses once on arrival.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    hold_d     = 1'b0;
    if (!stable_q) begin
      hold_cnt_d = '0;
    end else if (hold_cnt_q != HOLD_LAST) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
      hold_d     = (hold_cnt_q == HOLD_LAST - 1'b1);
    end
  end

  // Hold timer register.
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      hold_cnt_q <= '0;
      hold_q     <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      hold_q     <= hold_d;
    end
  end

  assign holdOut = hold_q;
`else
  assign holdOut = 1'b0;
`endif

endmodule : debounce_channel

// File: rtl/multi_button_debounce.sv
// NUM_CH independent button debouncers with press/release/any-press events.
// Long-press pulses on holdOut are built only when BUTTON_DEBOUNCE_HOLD_EN is defined.
module multi_button_debounce
  import button_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned DEBOUNCE_CNT = 16,
  parameter bit          ACTIVE_LOW   = 1'b0,
  parameter int unsigned HOLD_CNT     = 1024
) (
  input  logic              clkIn,
  input  logic              rstIn,
  input  logic [NUM_CH-1:0] buttonIn,
  output logic [NUM_CH-1:0] buttonOut,
  output logic [NUM_CH-1:0] pressOut,
  output logic [NUM_CH-1:0] releaseOut,
  output logic              anyPressOut,
  output logic [NUM_CH-1:0] holdOut
);

  if (NUM_CH == 0) begin : g_bad_num_ch
    $error("multi_button_debounce: NUM_CH must be >= 1");
  end

  // Channels share nothing but the clock and reset.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CNT (DEBOUNCE_CNT),
      .ACTIVE_LOW   (ACTIVE_LOW),
      .HOLD_CNT     (HOLD_CNT)
    ) u_channel (
      .clkIn      (clkIn),
      .rstIn      (rstIn),
      .buttonIn   (buttonIn[i]),
      .buttonOut  (buttonOut[i]),
      .pressOut   (pressOut[i]),
      .releaseOut (releaseOut[i]),
      .holdOut    (holdOut[i])
    );
  end

  // pressOut bits are already registered, so their OR lands in the same cycle.
  assign anyPressOut = |pressOut;

endmodule : multi_button_debounce

// File: tb/tb_multi_button_debounce.sv
// Scoreboard bench for multi_button_debounce: an active-high and an active-low
// instance see the same logical stimulus and must match one timestamp-based model.
// Compile with BUTTON_DEBOUNCE_HOLD_EN to also predict long-press pulses.
module tb_multi_button_debounce;

  localparam int NUM_CH       = 4;
  localparam int DEBOUNCE_CNT = 8;
  localparam int HOLD_CNT     = 20;

  typedef struct packed {
    logic [NUM_CH-1:0] btn;
    logic [NUM_CH-1:0] press;
    logic [NUM_CH-1:0] rel;
    logic [NUM_CH-1:0] hold;
    logic              any;
  } obs_t;

  logic              clkIn = 1'b0;
  logic              rstIn;
  logic [NUM_CH-1:0] buttonIn;
  logic [NUM_CH-1:0] buttonIn_n;

  logic [NUM_CH-1:0] btn_a, press_a, rel_a, hold_a;
  logic              any_a;
  logic [NUM_CH-1:0] btn_b, press_b, rel_b, hold_b;
  logic              any_b;
  obs_t              obs_a, obs_b;

  obs_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   model_presses = 0;
  int   seen_presses  = 0;
  bit   done = 1'b0;

  always #5 clkIn = ~clkIn;

  assign buttonIn_n = ~buttonIn;
  assign obs_a = {btn_a, press_a, rel_a, hold_a, any_a};
  assign obs_b = {btn_b, press_b, rel_b, hold_b, any_b};

  multi_button_debounce #(
    .NUM_CH(NUM_CH), .DEBOUNCE_CNT(DEBOUNCE_CNT), .ACTIVE_LOW(1'b0), .HOLD_CNT(HOLD_CNT)
  ) dut_hi (
    .clkIn(clkIn), .rstIn(rstIn), .buttonIn(buttonIn),
    .buttonOut(btn_a), .pressOut(press_a), .releaseOut(rel_a),
    .anyPressOut(any_a), .holdOut(hold_a)
  );

  multi_button_debounce #(
    .NUM_CH(NUM_CH), .DEBOUNCE_CNT(DEBOUNCE_CNT), .ACTIVE_LOW(1'b1), .HOLD_CNT(HOLD_CNT)
  ) dut_lo (
    .clkIn(clkIn), .rstIn(rstIn), .buttonIn(buttonIn_n),
    .buttonOut(btn_b), .pressOut(press_b), .releaseOut(rel_b),
    .anyPressOut(any_b), .holdOut(hold_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a level is accepted once the synchronised input has
  // disagreed with it on DEBOUNCE_CNT consecutive edges, measured as the
  // distance from the last edge where they agreed. Holds are timestamped.
  initial begin : model
    logic [NUM_CH-1:0] p1, p2, stable;
    int   agree_at   [NUM_CH];
    int   pressed_at [NUM_CH];
    int   edge_n;
    obs_t e;
    p1 = '0; p2 = '0; stable = '0; edge_n = 0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      agree_at[ch]   = 0;
      pressed_at[ch] = -1;
    end
    forever begin
      @(posedge clkIn);
      if (!done) begin
        edge_n++;
        e = '0;
        if (rstIn) begin
          p1 = '0; p2 = '0; stable = '0;
          for (int ch = 0; ch < NUM_CH; ch++) begin
            agree_at[ch]   = edge_n;
            pressed_at[ch] = -1;
          end
        end else begin
          for (int ch = 0; ch < NUM_CH; ch++) begin
`ifdef BUTTON_DEBOUNCE_HOLD_EN
            if (pressed_at[ch] >= 0 && edge_n - pressed_at[ch] == HOLD_CNT) e.hold[ch] = 1'b1;
`endif
            if (p2[ch] == stable[ch]) begin
              agree_at[ch] = edge_n;
            end else if (edge_n - agree_at[ch] == DEBOUNCE_CNT) begin
              stable[ch]   = p2[ch];
              agree_at[ch] = edge_n;
              if (p2[ch]) begin
                e.press[ch]    = 1'b1;
                pressed_at[ch] = edge_n;
                model_presses++;
              end else begin
                e.rel[ch]      = 1'b1;
                pressed_at[ch] = -1;
              end
            end
          end
          p2 = p1;
          p1 = buttonIn;
        end
        e.btn = stable;
        e.any = |e.press;
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: every cycle the DUTs present a full output set, compared mid-cycle.
  initial begin : monitor
    obs_t e;
    int   cyc;
    cyc = 0;
    @(posedge clkIn);
    forever begin
      @(negedge clkIn);
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("cyc%0d active_high", cyc), 32'(obs_a), 32'(e));
        check($sformatf("cyc%0d active_low", cyc), 32'(obs_b), 32'(e));
        seen_presses += $countones(press_a);
      end else if (!done) begin
        n_tests++;
        n_fail++;
        $display("FAIL cyc%0d scoreboard: got no expected entry, expected one per cycle", cyc);
      end
    end
  end

  task automatic drive(input logic r, input logic [NUM_CH-1:0] b, input int n);
    repeat (n) begin
      @(negedge clkIn);
      rstIn    = r;
      buttonIn = b;
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [NUM_CH-1:0] cur;
    rstIn    = 1'b1;
    buttonIn = '1;
    // Reset for three edges with all buttons down, then release and watch them settle.
    drive(1'b1, '1, 2);
    cur = '1;
    drive(1'b0, cur, 20);

    // Clean level changes on random channel patterns.
    for (int k = 0; k < 8; k++) begin
      cur = NUM_CH'($urandom);
      drive(1'b0, cur, $urandom_range(12, 30));
    end

    // Clean single press on ch0 with the others idle.
    cur = '0;
    drive(1'b0, cur, 15);
    cur[0] = 1'b1;
    drive(1'b0, cur, 15);

    // Ch1 bounces every 3 cycles for ~40 cycles, then settles pressed.
    for (int k = 0; k < 14; k++) begin
      cur[1] = ~cur[1];
      drive(1'b0, cur, 3);
    end
    cur[1] = 1'b1;
    drive(1'b0, cur, 15);

    // Ch2 pressed while ch3 released on the same edge.
    cur[2] = 1'b0; cur[3] = 1'b1;
    drive(1'b0, cur, 15);
    cur[2] = 1'b1; cur[3] = 1'b0;
    drive(1'b0, cur, 15);

    // Reset pulses at various points of an in-progress count.
    for (int k = 0; k < 6; k++) begin
      cur = ~cur;
      drive(1'b0, cur, 2 + $urandom_range(1, 7));
      drive(1'b1, cur, 1);
      drive(1'b0, cur, 15);
    end

    // Ch0 held just short of, and exactly at, the long-press window.
    cur = '0;
    drive(1'b0, cur, 30);
    cur[0] = 1'b1; drive(1'b0, cur, HOLD_CNT - 1);
    cur[0] = 1'b0; drive(1'b0, cur, 30);
    cur[0] = 1'b1; drive(1'b0, cur, HOLD_CNT);
    cur[0] = 1'b0; drive(1'b0, cur, 30);
    cur[0] = 1'b1; drive(1'b0, cur, 3 * HOLD_CNT);

    // Long random holds around the hold window.
    for (int k = 0; k < 12; k++) begin
      cur = NUM_CH'($urandom);
      drive(1'b0, cur, $urandom_range(20, 50));
    end

    // Random mix of changes, single-cycle glitches and occasional resets.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 19) == 0) cur = NUM_CH'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        drive(1'b0, cur ^ NUM_CH'(1 << $urandom_range(0, NUM_CH - 1)), 1);
      end else if ($urandom_range(0, 299) == 0) begin
        drive(1'b1, cur, 1);
      end else begin
        drive(1'b0, cur, 1);
      end
    end
    drive(1'b0, cur, 20);

    // Let the last stimulus be modelled, then stop predicting and drain.
    @(posedge clkIn);
    #1 done = 1'b1;
    @(negedge clkIn);
    @(negedge clkIn);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("press_event_count", 32'(seen_presses), 32'(model_presses));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_multi_button_debounce
